// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the 16-bit CPU front end
package cpu_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} fetch_state_t;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 13;
  localparam int INST_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches one instruction at a time and hands it to decode
import cpu_pkg::*;
module fetch_unit #(
  parameter logic [15:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_rvalid,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready
);
  fetch_state_t state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic capture;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nxt;
  // a redirect while a request is in flight must wait out the stale response in DRAIN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     state_nxt = redirect ? DRAIN : WAIT;
      WAIT:    state_nxt = redirect ? (imem_rvalid ? REQ : DRAIN) : (imem_rvalid ? HOLD : WAIT);
      HOLD:    state_nxt = (redirect || inst_ready) ? REQ : HOLD;
      DRAIN:   state_nxt = imem_rvalid ? REQ : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  assign capture = (state == WAIT) && imem_rvalid && !redirect;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      pc <= RESET_PC;
      inst <= '0;
      inst_pc <= '0;
    end else begin
      pc <= redirect ? redirect_pc : capture ? pc + ADDR_W'(1) : pc;
      if (capture) begin
        inst <= imem_rdata;
        inst_pc <= pc;
      end
    end
  always_comb begin
    imem_req = state == REQ;
    imem_addr = pc;
    inst_valid = state == HOLD;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios checked against a PC-sequence model
`timescale 1ns/1ps
module tb_fetch_unit;
  logic Clock = 0, Reset = 1;
  logic imem_req, imem_rvalid = 0, redirect = 0, inst_valid, inst_ready = 1;
  logic [15:0] imem_addr, imem_rdata = 0, redirect_pc = 0, inst, inst_pc;
  int vectors = 0, miscompares = 0, cyc = 0, lat = 1, cnt = 0;
  int rel_cyc = 0, first_valid_cyc = -1;
  logic [15:0] mem_addr = 0, exp_pc = 0, pinst = 0, ppc = 0;
  logic pv = 0, pacc = 0, predir = 0;
  logic [15:0] got_pc[$], got_inst[$], acc_q[$];
  int req_cyc[$];

  fetch_unit dut (
    .Clock(Clock), .Reset(Reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // memory: answers each request lat cycles later, one outstanding at most
  always @(negedge Clock) begin
    imem_rvalid = 0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1;
        imem_rdata = mem_word(mem_addr);
      end
    end
    if (imem_req && !Reset) begin
      chk("one_outstanding", 16'(cnt), 16'd0);
      cnt = lat;
      mem_addr = imem_addr;
    end
  end

  // model: the delivered stream must follow the PC sequence, reset by redirects
  always @(negedge Clock) begin
    if (Reset) begin
      chk("rst_valid", {15'd0, inst_valid}, 16'd0);
      chk("rst_req", {15'd0, imem_req}, 16'd0);
      chk("rst_inst", inst, 16'h0000);
      chk("rst_inst_pc", inst_pc, 16'h0000);
      exp_pc = 16'h0000;
      pv = 0; pacc = 0; predir = 0;
    end else begin
      if (imem_req) begin
        chk("req_addr", imem_addr, exp_pc);
        chk("req_while_valid", {15'd0, inst_valid}, 16'd0);
        req_cyc.push_back(cyc);
      end
      if (pacc) chk("accept_drops_valid", {15'd0, inst_valid}, 16'd0);
      else if (pv && !predir) begin
        chk("hold_valid", {15'd0, inst_valid}, 16'd1);
        chk("hold_inst", inst, pinst);
        chk("hold_inst_pc", inst_pc, ppc);
      end
      if (inst_valid && !pv) begin
        chk("new_inst_pc", inst_pc, exp_pc);
        chk("new_inst", inst, mem_word(inst_pc));
        exp_pc = inst_pc + 16'd1;
        got_pc.push_back(inst_pc);
        got_inst.push_back(inst);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (inst_valid && inst_ready) acc_q.push_back(inst_pc);
      pv = inst_valid; pacc = inst_valid && inst_ready; predir = redirect;
      pinst = inst; ppc = inst_pc;
      if (redirect) exp_pc = redirect_pc;
    end
  end

  task automatic wait_valid_pc(input logic [15:0] p);
    int n = 0;
    while (!(inst_valid && inst_pc == p) && n < 60) begin
      @(posedge Clock); #1;
      n++;
    end
    vectors++;
    if (!(inst_valid && inst_pc == p)) begin
      miscompares++;
      $display("FAIL wait_pc_%h: timed out with inst_pc=%h inst_valid=%b, required valid at %h", p, inst_pc, inst_valid, p);
    end
  endtask

  task automatic cycle();
    @(posedge Clock); #1;
  endtask

  initial begin
    int n;
    int acc40;
    repeat (2) @(posedge Clock);
    #1;
    rel_cyc = cyc;
    Reset = 0;
    wait_valid_pc(16'h0001);
    cycle();
    inst_ready = 0;
    wait_valid_pc(16'h0002);
    repeat (5) cycle();
    chk("stall_inst", inst, 16'hA002);
    inst_ready = 1;
    cycle();
    chk("after_ready_req", {15'd0, imem_req}, 16'd1);
    chk("after_ready_addr", imem_addr, 16'h0003);
    chk("first_three_pc", {got_pc[0][3:0], got_pc[1][3:0], got_pc[2][3:0], 4'h0}, 16'h0120);
    chk("first_inst", got_inst[0], 16'hA000);
    chk("third_inst", got_inst[2], 16'hA002);
    chk("first_valid_latency", 16'(first_valid_cyc - rel_cyc), 16'd3);
    chk("req_spacing", 16'(req_cyc[1] - req_cyc[0]), 16'd3);
    lat = 3;
    cycle();
    redirect = 1; redirect_pc = 16'h0040;
    cycle();
    redirect = 0;
    n = 0;
    while (!imem_req && n < 20) begin cycle(); n++; end
    chk("redirect_req", {15'd0, imem_req}, 16'd1);
    chk("redirect_addr", imem_addr, 16'h0040);
    lat = 1;
    wait_valid_pc(16'h0040);
    chk("redirect_inst", inst, 16'hA040);
    redirect = 1; redirect_pc = 16'h0080;
    cycle();
    redirect = 0;
    wait_valid_pc(16'h0080);
    acc40 = 0;
    foreach (acc_q[i]) if (acc_q[i] == 16'h0040) acc40++;
    chk("hold_redirect_accept_once", 16'(acc40), 16'd1);
    redirect = 1; redirect_pc = 16'hFFFF;
    cycle();
    redirect = 0;
    wait_valid_pc(16'hFFFF);
    chk("top_inst", inst, 16'h9FFF);
    wait_valid_pc(16'h0000);
    chk("wrap_inst", inst, 16'hA000);
    wait_valid_pc(16'h0001);
    lat = 3;
    cycle();
    chk("pre_reset_req", {15'd0, imem_req}, 16'd1);
    chk("pre_reset_addr", imem_addr, 16'h0002);
    cycle();
    #2 Reset = 1;
    #1;
    chk("async_inst", inst, 16'h0000);
    chk("async_inst_pc", inst_pc, 16'h0000);
    chk("async_valid", {15'd0, inst_valid}, 16'd0);
    chk("async_addr", imem_addr, 16'h0000);
    cycle();
    lat = 1;
    Reset = 0;
    wait_valid_pc(16'h0000);
    chk("post_reset_inst", inst, 16'hA000);
    wait_valid_pc(16'h0001);
    repeat (2) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 16-bit CPU; owns the program counter.
- Issues word-addressed requests to instruction memory and captures the returned 16-bit instruction.
- Presents the instruction, tagged with its PC, to decode/control over a valid/ready handshake.
- Accepts PC redirects (branch/jump) from the datapath and discards stale in-flight fetches.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- ADDR_W, 16, PC / instruction-memory address width (fixed 16 in this CPU).

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request strobe; one cycle per request.
- imem_addr  out  16  word address of the request; equals pc.
- imem_rdata  in  16  instruction word from memory.
- imem_rvalid  in  1  imem_rdata valid this cycle; latency 1 or more cycles after imem_req.
- redirect  in  1  load redirect_pc as next fetch address (branch taken/jump).
- redirect_pc  in  16  redirect target.
- inst  out  16  captured instruction; opcode in inst[15:13].
- inst_pc  out  16  address inst was fetched from.
- inst_valid  out  1  inst/inst_pc valid to decode.
- inst_ready  in  1  decode accepts inst this cycle.

Behaviour:
- Reset (async, any time, including mid-fetch):
  - pc=RESET_PC, state=IDLE.
  - inst_valid=0, inst=16'h0000, inst_pc=16'h0000, imem_req=0.
  - A response arriving after reset deasserts is never captured unless requested post-reset.
- At most one outstanding memory request. imem_req = (state==REQ); imem_addr = pc (combinational from pc register).
- States and transitions:
  - IDLE: one cycle after reset release -> REQ.
  - REQ: imem_req=1 for exactly this cycle -> WAIT.
  - WAIT: on imem_rvalid -> inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+1 (mod 2^16; 16'hFFFF wraps to 16'h0000) -> HOLD.
  - HOLD: inst_valid=1, and inst/inst_pc are stable while inst_ready=0. On inst_ready: inst_valid<=0 -> REQ.
  - DRAIN: waiting for a stale response. On imem_rvalid, drop the data (no capture, pc unchanged) -> REQ.
- Redirect has highest priority and is evaluated in every state:
  - IDLE/REQ/HOLD: pc<=redirect_pc, inst_valid<=0 -> REQ.
  - REQ + redirect: the request issued that cycle is in flight -> DRAIN instead of REQ.
  - WAIT: pc<=redirect_pc -> DRAIN. If imem_rvalid arrives in the same cycle, the data is dropped and the next state is REQ.
  - DRAIN: pc<=redirect_pc; stay in DRAIN, or go to REQ if imem_rvalid is asserted that cycle.
  - HOLD with inst_ready=1 in the same cycle: the handshake completes (decode consumed inst), then the redirect applies.
- Throughput: 1 instruction per (3 + extra memory latency) cycles minimum.
- Latency: with single-cycle memory, reset release to first inst_valid is 3 cycles.
- imem_rvalid in IDLE, REQ or HOLD is a protocol error and is ignored.

Decomposition:
- cpu_pkg holds:
  - fetch state enum {IDLE, REQ, WAIT, HOLD, DRAIN};
  - OPCODE_MSB=15, OPCODE_LSB=13;
  - INST_W=16, ADDR_W=16;
  - RESET_PC default.
- Single module with no sub-module. The pc register with increment/redirect mux stays inline.

Test Plan:
- Reset, 1-cycle memory returning mem[a]=16'hA000+a, inst_ready=1 -> inst_pc sequence 0,1,2,... with inst=16'hA000,16'hA001,...; imem_req once per 3 cycles.
- inst_ready held 0 for 5 cycles after inst_pc=2 -> inst=16'hA002 and inst_valid stay stable, no imem_req issued; 1 cycle after ready, imem_addr=3.
- redirect=1, redirect_pc=16'h0040 during WAIT with 3-cycle latency -> stale data dropped (never on inst); next request addr 16'h0040; next inst_pc=16'h0040.
- redirect during HOLD with inst_ready=1 -> current inst accepted once; next fetch from redirect_pc, not pc+1.
- redirect to 16'hFFFF -> inst_pc=16'hFFFF, then next inst_pc=16'h0000 (wrap).
- Assert Reset asynchronously mid-WAIT -> outputs clear immediately without a clock edge; the late imem_rvalid is ignored; fetching restarts at RESET_PC.
